// File: rtl/ltc6912_spi_responder_pkg.sv
// Shared constants, state encoding and gain-field helper for the LTC6912 serial-port responder.
package ltc6912_spi_responder_pkg;

   localparam int LTC6912_WORD_BITS = 8;
   localparam int GAIN_BITS         = 4;
   localparam int GAIN_A_LSB        = 0;
   localparam int GAIN_B_LSB        = 4;

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      SHIFT     = 2'd2
   } state_t;

   function automatic logic [GAIN_BITS-1:0] gain_field(
      input logic [LTC6912_WORD_BITS-1:0] word,
      input int                           lsb
   );
      return word[lsb +: GAIN_BITS];
   endfunction

endpackage

// File: rtl/ltc6912_spi_responder_if.sv
// SPI pin bundle between an LTC6912 gain-word driver (master) and the responder (slave).
interface ltc6912_spi_responder_if;
   import ltc6912_spi_responder_pkg::*;

   logic cs;
   logic sck;
   logic mosi;
   logic sdo;
   logic sdo_oe;

   modport master (
      output cs,
      output sck,
      output mosi,
      input  sdo,
      input  sdo_oe
   );

   modport slave (
      input  cs,
      input  sck,
      input  mosi,
      output sdo,
      output sdo_oe
   );

endinterface

// File: rtl/ltc6912_spi_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall strobes
// derived from the synchronized level and its previous-cycle value.
module ltc6912_spi_responder_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic level_s,
   output logic rise_s,
   output logic fall_s
);

   logic [SYNC_STAGES-1:0] stage_r;
   logic                   prev_r;

   // Shift the pin through the synchronizer chain and remember the last synchronized level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_r <= {SYNC_STAGES{1'b0}};
         prev_r  <= 1'b0;
      end else begin
         stage_r <= {stage_r[SYNC_STAGES-2:0], pin};
         prev_r  <= stage_r[SYNC_STAGES-1];
      end
   end

   assign level_s = stage_r[SYNC_STAGES-1];
   assign rise_s  = level_s & ~prev_r;
   assign fall_s  = ~level_s & prev_r;

endmodule

// File: rtl/ltc6912_spi_responder.sv
// Target-side LTC6912 serial port: oversamples cs/sck/mosi, captures one gain word per
// frame, commits it on cs rise and returns the previously held word on sdo.
module ltc6912_spi_responder
   import ltc6912_spi_responder_pkg::*;
#(
   parameter int                    WORD_BITS   = LTC6912_WORD_BITS,
   parameter int                    SYNC_STAGES = 2,
   parameter logic [WORD_BITS-1:0]  RESET_GAIN  = 8'h00
) (
   input  logic                    clk,
   input  logic                    reset_n,
   ltc6912_spi_responder_if.slave  spi,
   output logic [GAIN_BITS-1:0]    gain_a,
   output logic [GAIN_BITS-1:0]    gain_b,
   output logic                    word_valid,
   output logic                    frame_err
);

   localparam int                CNT_W      = $clog2(WORD_BITS + 2);
   localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(WORD_BITS);
   localparam logic [CNT_W-1:0]  COUNT_SAT  = CNT_W'(WORD_BITS + 1);
   localparam logic [CNT_W-1:0]  COUNT_ONE  = CNT_W'(1'b1);

   logic cs_s;
   logic cs_rise_s;
   logic cs_fall_s;
   logic sck_level_unused_s;
   logic sck_rise_s;
   logic sck_fall_s;
   logic mosi_s;
   logic mosi_rise_unused_s;
   logic mosi_fall_unused_s;

   state_t                 state_r;
   logic [WORD_BITS-1:0]   gain_r;
   logic [WORD_BITS-1:0]   rx_sr_r;
   logic [WORD_BITS-1:0]   tx_sr_r;
   logic [CNT_W-1:0]       count_r;
   logic                   sdo_r;
   logic                   sdo_oe_r;
   logic                   word_valid_r;
   logic                   frame_err_r;

   ltc6912_spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (spi.cs),
      .level_s (cs_s),
      .rise_s  (cs_rise_s),
      .fall_s  (cs_fall_s)
   );

   ltc6912_spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (spi.sck),
      .level_s (sck_level_unused_s),
      .rise_s  (sck_rise_s),
      .fall_s  (sck_fall_s)
   );

   ltc6912_spi_responder_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (spi.mosi),
      .level_s (mosi_s),
      .rise_s  (mosi_rise_unused_s),
      .fall_s  (mosi_fall_unused_s)
   );

   // Frame FSM: capture, shift-out, commit/error pulses; cs rise outranks any coincident sck edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= WAIT_IDLE;
         gain_r       <= RESET_GAIN;
         rx_sr_r      <= {WORD_BITS{1'b0}};
         tx_sr_r      <= {WORD_BITS{1'b0}};
         count_r      <= {CNT_W{1'b0}};
         sdo_r        <= 1'b0;
         sdo_oe_r     <= 1'b0;
         word_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         word_valid_r <= 1'b0;
         frame_err_r  <= 1'b0;
         case (state_r)
            WAIT_IDLE: begin
               // A frame already in progress at reset release is dropped silently.
               if (cs_s) begin
                  state_r <= IDLE;
               end
            end
            IDLE: begin
               if (cs_fall_s) begin
                  state_r  <= SHIFT;
                  count_r  <= {CNT_W{1'b0}};
                  tx_sr_r  <= gain_r;
                  sdo_r    <= gain_r[WORD_BITS-1];
                  sdo_oe_r <= 1'b1;
               end
            end
            SHIFT: begin
               if (cs_rise_s) begin
                  state_r  <= IDLE;
                  sdo_oe_r <= 1'b0;
                  sdo_r    <= 1'b0;
                  if (count_r == COUNT_FULL) begin
                     gain_r       <= rx_sr_r;
                     word_valid_r <= 1'b1;
                  end else begin
                     frame_err_r  <= 1'b1;
                  end
               end else if (sck_rise_s) begin
                  rx_sr_r <= {rx_sr_r[WORD_BITS-2:0], mosi_s};
                  if (count_r != COUNT_SAT) begin
                     count_r <= count_r + COUNT_ONE;
                  end
               end else if (sck_fall_s) begin
                  tx_sr_r <= {tx_sr_r[WORD_BITS-2:0], 1'b0};
                  sdo_r   <= tx_sr_r[WORD_BITS-2];
               end
            end
            default: begin
               state_r  <= WAIT_IDLE;
               sdo_oe_r <= 1'b0;
               sdo_r    <= 1'b0;
            end
         endcase
      end
   end

   assign spi.sdo    = sdo_r;
   assign spi.sdo_oe = sdo_oe_r;
   assign gain_a     = gain_field(gain_r, GAIN_A_LSB);
   assign gain_b     = gain_field(gain_r, GAIN_B_LSB);
   assign word_valid = word_valid_r;
   assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_ltc6912_spi_responder.sv
// Directed-frame bench for the LTC6912 responder: stimulus queues expected pulses and sdo
// bits, independent monitors pop and compare as the responder presents them.
module tb_ltc6912_spi_responder;

   localparam int HALF = 500;

   typedef struct packed {
      logic       is_err;
      logic [7:0] word;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] gain_a;
   logic [3:0] gain_b;
   logic       word_valid;
   logic       frame_err;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic sdo_q[$];
   logic [7:0] model_gain;

   ltc6912_spi_responder_if spi ();

   ltc6912_spi_responder dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .spi        (spi),
      .gain_a     (gain_a),
      .gain_b     (gain_b),
      .word_valid (word_valid),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_sdo(input logic [7:0] held, input int n);
      for (int i = 0; i < n; i++) begin
         sdo_q.push_back((i < 8) ? held[7-i] : 1'b0);
      end
   endtask

   task automatic shift_bits(input logic [15:0] data, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         spi.mosi = data[nbits-1-i];
         #HALF;
         spi.sck = 1'b1;
         #HALF;
         spi.sck = 1'b0;
      end
      spi.mosi = 1'b0;
      #HALF;
   endtask

   task automatic frame(input logic [15:0] data, input int nbits);
      push_sdo(model_gain, nbits);
      spi.cs = 1'b0;
      #100;
      check("sdo_oe_active", spi.sdo_oe, 1'b1);
      shift_bits(data, nbits);
      if (nbits == 8) begin
         exp_q.push_back(exp_t'({1'b0, data[7:0]}));
         model_gain = data[7:0];
      end else begin
         exp_q.push_back(exp_t'({1'b1, model_gain}));
      end
      spi.cs = 1'b1;
      #100;
      check("sdo_oe_idle", spi.sdo_oe, 1'b0);
      #HALF;
   endtask

   // Pulse monitor: every word_valid/frame_err pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (word_valid || frame_err) begin
         check("pulse_exclusive", {31'd0, word_valid & frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got wv=%0b fe=%0b expected none at %0t",
                     word_valid, frame_err, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pulse_kind_fe", {31'd0, frame_err}, {31'd0, e.is_err});
            check("pulse_gain", {24'd0, gain_b, gain_a}, {24'd0, e.word});
         end
      end
   end

   // Readback monitor: sdo as the master would sample it on each sck rise inside a frame.
   always @(posedge spi.sck) begin
      if (spi.cs == 1'b0) begin
         if (sdo_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sck: got sdo=%0b expected no bit at %0t", spi.sdo, $time);
         end else begin
            check("sdo_bit", {31'd0, spi.sdo}, {31'd0, sdo_q.pop_front()});
         end
      end
   end

   initial begin
      spi.cs     = 1'b1;
      spi.sck    = 1'b0;
      spi.mosi   = 1'b0;
      reset_n    = 1'b0;
      model_gain = 8'h00;

      // Reset state
      #52;
      check("gain_a_reset", gain_a, 4'h0);
      check("gain_b_reset", gain_b, 4'h0);
      check("sdo_oe_reset", spi.sdo_oe, 1'b0);
      check("sdo_reset", spi.sdo, 1'b0);
      check("word_valid_reset", word_valid, 1'b0);
      check("frame_err_reset", frame_err, 1'b0);
      reset_n = 1'b1;
      #200;
      check("sdo_oe_after_release", spi.sdo_oe, 1'b0);

      // Normal frames, with readback of the previous word
      frame(16'h0077, 8);
      frame(16'h0035, 8);

      // Short, long and empty frames
      frame(16'h002B, 7);
      frame(16'h01AB, 9);
      frame(16'h0000, 0);
      check("gain_a_hold", gain_a, 4'h5);
      check("gain_b_hold", gain_b, 4'h3);

      // Reset mid-frame, released while cs is still low
      push_sdo(model_gain, 4);
      spi.cs = 1'b0;
      #100;
      shift_bits(16'h000A, 4);
      reset_n = 1'b0;
      #50;
      check("gain_a_midreset", gain_a, 4'h0);
      check("gain_b_midreset", gain_b, 4'h0);
      check("sdo_oe_midreset", spi.sdo_oe, 1'b0);
      reset_n = 1'b1;
      model_gain = 8'h00;
      #HALF;
      push_sdo(8'h00, 4);
      shift_bits(16'h0005, 4);
      spi.cs = 1'b1;
      #HALF;
      check("sdo_oe_dropped", spi.sdo_oe, 1'b0);
      check("gain_a_dropped", gain_a, 4'h0);
      check("gain_b_dropped", gain_b, 4'h0);
      frame(16'h00C3, 8);

      // cs rise coincident with a 9th sck rise: cs wins, 8 bits counted
      push_sdo(model_gain, 8);
      spi.cs = 1'b0;
      #100;
      check("sdo_oe_aligned", spi.sdo_oe, 1'b1);
      shift_bits(16'h006B, 8);
      exp_q.push_back(exp_t'({1'b0, 8'h6B}));
      model_gain = 8'h6B;
      spi.cs  = 1'b1;
      spi.sck = 1'b1;
      #HALF;
      spi.sck = 1'b0;
      check("sdo_oe_aligned_end", spi.sdo_oe, 1'b0);
      #HALF;

      // Back-to-back frames with cs high across a single clk edge
      push_sdo(model_gain, 8);
      spi.cs = 1'b0;
      #100;
      shift_bits(16'h0012, 8);
      exp_q.push_back(exp_t'({1'b0, 8'h12}));
      model_gain = 8'h12;
      spi.cs = 1'b1;
      #12;
      push_sdo(model_gain, 8);
      spi.cs = 1'b0;
      #100;
      check("sdo_oe_b2b", spi.sdo_oe, 1'b1);
      shift_bits(16'h009E, 8);
      exp_q.push_back(exp_t'({1'b0, 8'h9E}));
      model_gain = 8'h9E;
      spi.cs = 1'b1;
      #HALF;
      check("gain_a_final", gain_a, 4'hE);
      check("gain_b_final", gain_b, 4'h9);

      #500;
      check("pulse_queue_drained", exp_q.size(), 32'd0);
      check("sdo_queue_drained", sdo_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
